multicycle_mainfsm: RTL
=======================

Name: multicycle_mainfsm

Overview:
Main control FSM for the multicycle RV32I core; sits directly upstream of aludec and drives its ALUOp input. Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states from the opcode held in the instruction register. Produces datapath muxes and write strobes as Moore outputs of the state. A mem_ready handshake stretches memory-access states.

Parameters:
STATE_W, 4, width of the state register and the state_o debug port (minimum 4).

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  synchronous reset, active-low
op  in  7  opcode field instr[6:0] from instruction register
mem_ready  in  1  unified memory completes the access this cycle
PCUpdate  out  1  PC write strobe (ORed with Branch&Zero outside this block)
Branch  out  1  conditional branch enable
RegWrite  out  1  register file write strobe
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction register / OldPC write strobe
AdrSrc  out  1  0 = PC, 1 = ALUOut drives memory address
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data
ALUSrcB  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
ALUOp  out  2  to aludec: 00 add, 01 subtract, 10 decode funct fields
illegal_op  out  1  one-cycle pulse when Decode sees an unsupported opcode
state_o  out  STATE_W  current state encoding (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11..15 are unreachable and recover to FETCH on the next edge.
- Reset: on any rising edge with reset_n=0, state <= FETCH, regardless of the current state, including mid-instruction. While reset_n=0, PCUpdate, RegWrite, MemWrite, IRWrite, Branch and illegal_op are forced 0. Every other output holds its FETCH value (all zero except ALUSrcB=10, ResultSrc=10).
- All outputs are decoded combinationally from state only, except where the mem_ready gating below applies. Outputs not listed for a state are 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target calculation). Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=mem_ready. Holds until mem_ready=1, then goes to FETCH. The MemWrite strobe is high in exactly one cycle.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- Latency with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4, illegal 2.
- op is sampled only in DECODE and MEMADR; changes to op in other states have no effect.

Test Plan:
- lw (op=0000011), mem_ready=1 -> state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. IRWrite pulses once in cycle 0.
- sw (op=0100011), mem_ready low for 3 cycles in both FETCH and MEMWRITE -> FETCH held 3 cycles with IRWrite=0; sequence 0,1,2,5,0; MemWrite=1 in exactly one cycle, with AdrSrc=1.
- R-type (op=0110011) -> sequence 0,1,6,8,0. ALUOp=10 in state 6, ALUSrcA=10, ALUSrcB=00. RegWrite=1 in state 8.
- beq (op=1100011) -> sequence 0,1,9,0. Branch=1 and ALUOp=01 in state 9. jal (op=1101111) -> sequence 0,1,10,8,0, with PCUpdate=1 in state 10.
- Illegal opcode (op=1111111) -> DECODE asserts illegal_op=1 for one cycle and returns to FETCH. No RegWrite or MemWrite at any point.
- reset_n=0 asserted while in MEMWRITE with mem_ready=1 -> MemWrite stays 0 that cycle and state_o=0 after the edge. Deassert reset_n -> a normal fetch resumes.

Source files
------------

// File: rtl/multicycle_mainfsm.sv
// Main control FSM of the multicycle RV32I core: sequences Fetch/Decode/Execute/
// Memory/Writeback from the IR opcode and decodes Moore datapath controls.
module multicycle_mainfsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic               PCUpdate,
  output logic               Branch,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem_ready;
        PCUpdate   = mem_ready;
        state_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = mem_ready;
        state_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCUpdate   = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase

    // During reset the controls look like an idle FETCH with every strobe suppressed.
    if (!reset_n) begin
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      illegal_op = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b10;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b10;
      ALUOp      = 2'b00;
    end
  end

  assign state_o = state;

endmodule
